// File: rtl/alu_rr_dispatch_pkg.sv
// Shared definitions for the R-type ALU dispatcher.
//   state_t      : dispatcher FSM encoding (IDLE, SELECT, WAIT, WRITE)
//   OPCODE_OP    : RV32 OP major opcode (register-register ALU ops)
//   FUNCT7_BASE  : funct7 of the base ops (add, sll, slt, ...)
//   FUNCT7_EXTRA : funct7 of the alternate ops (sub, sra)
//   rr_fields_t  : register/function fields pulled out of an R-type word
package alu_rr_dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    WAIT   = 2'd2,
    WRITE  = 2'd3
  } state_t;

  localparam logic [6:0] OPCODE_OP    = 7'b0110011;
  localparam logic [6:0] FUNCT7_BASE  = 7'h00;
  localparam logic [6:0] FUNCT7_EXTRA = 7'h20;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
  } rr_fields_t;

endpackage

// File: rtl/alu_rr_dispatch_if.sv
// Bus bundle between the instruction source / ALU / register file and the
// dispatcher.
//   slave  : dispatcher side (consumes instructions and ALU results,
//            drives register-file addresses, ALU select strobe, write port,
//            done/timeout pulses)
//   master : environment side (mirror image)
// Build option: ALU_RR_ILLEGAL_TRAP_EN adds the 'illegal' pulse signal.
interface alu_rr_dispatch_if #(
  parameter int XLEN = 32
);

  logic            instr_valid;
  logic [31:0]     instr;
  logic            instr_ready;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic            alu_select_enable;
  logic [6:0]      funct7;
  logic [2:0]      funct3;
  logic            alu_result_valid;
  logic [XLEN-1:0] alu_result;
  logic            rd_we;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] rd_wdata;
  logic            done;
  logic            timeout;
`ifdef ALU_RR_ILLEGAL_TRAP_EN
  logic            illegal;
`endif

  modport slave (
`ifdef ALU_RR_ILLEGAL_TRAP_EN
    output illegal,
`endif
    input  instr_valid, instr, alu_result_valid, alu_result,
    output instr_ready, rs1_addr, rs2_addr, alu_select_enable, funct7,
           funct3, rd_we, rd_addr, rd_wdata, done, timeout
  );

  modport master (
`ifdef ALU_RR_ILLEGAL_TRAP_EN
    input  illegal,
`endif
    output instr_valid, instr, alu_result_valid, alu_result,
    input  instr_ready, rs1_addr, rs2_addr, alu_select_enable, funct7,
           funct3, rd_we, rd_addr, rd_wdata, done, timeout
  );

endinterface

// File: rtl/alu_rr_dispatch_decode.sv
// rr_instr_decode: purely combinational field extraction and legality check
// for an R-type instruction word.
//   instr   in  32  instruction word
//   fields  out     rd / funct3 / rs1 / rs2 / funct7
//   illegal out 1   wrong opcode, unknown funct7, or a funct7=0x20 op other
//                   than sub/sra (funct3 000/101)
module rr_instr_decode
  import alu_rr_dispatch_pkg::*;
(
  input  logic [31:0] instr,
  output rr_fields_t  fields,
  output logic        illegal
);

  logic [6:0] opcode;
  logic       bad_funct7;
  logic       bad_extra_op;

  assign opcode        = instr[6:0];
  assign fields.rd     = instr[11:7];
  assign fields.funct3 = instr[14:12];
  assign fields.rs1    = instr[19:15];
  assign fields.rs2    = instr[24:20];
  assign fields.funct7 = instr[31:25];

  assign bad_funct7   = (fields.funct7 != FUNCT7_BASE) && (fields.funct7 != FUNCT7_EXTRA);
  assign bad_extra_op = (fields.funct7 == FUNCT7_EXTRA) &&
                        (fields.funct3 != 3'b000) && (fields.funct3 != 3'b101);

  assign illegal = (opcode != OPCODE_OP) || bad_funct7 || bad_extra_op;

endmodule

// File: rtl/alu_rr_dispatch.sv
// alu_rr_dispatch: accepts one R-type instruction at a time, strobes the ALU
// selector, waits (bounded by TIMEOUT cycles) for the ALU result and writes
// it back to the register file.
//   clock  in  sole clock, rising edge
//   reset  in  synchronous, active-high
//   bus    alu_rr_dispatch_if.slave: instr handshake, rs1/rs2 addresses,
//          alu_select_enable + funct7/funct3, ALU result input, rd write
//          port, done / timeout pulses
// Parameters: XLEN datapath width, TIMEOUT max WAIT cycles (1..255).
// Build option: ALU_RR_ILLEGAL_TRAP_EN traps illegal words with a one-cycle
// 'illegal' pulse instead of dispatching them.
module alu_rr_dispatch
  import alu_rr_dispatch_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 15
) (
  input logic              clock,
  input logic              reset,
  alu_rr_dispatch_if.slave bus
);

  // Last WAIT cycle index; the counter runs 0..TIMEOUT-1.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t          state_q, state_d;
  rr_fields_t      fields_q;
  rr_fields_t      dec_fields;
  logic            dec_illegal;
  logic [7:0]      wait_cnt_q;
  logic [XLEN-1:0] wdata_q;
  logic            accept;
  logic            timeout_hit;
  logic            dispatch_ok;

  rr_instr_decode u_decode (
    .instr   (bus.instr),
    .fields  (dec_fields),
    .illegal (dec_illegal)
  );

`ifdef ALU_RR_ILLEGAL_TRAP_EN
  logic illegal_q;
  assign dispatch_ok = ~dec_illegal;
  assign bus.illegal = illegal_q;
`else
  // Without the trap every accepted word is dispatched.
  logic unused_illegal;
  assign dispatch_ok    = 1'b1;
  assign unused_illegal = dec_illegal;
`endif

  // Next-state logic. The timeout abort is decided in the last WAIT cycle;
  // a result arriving in that same cycle takes priority.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    accept      = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.instr_valid) begin
          accept = 1'b1;
          if (dispatch_ok) state_d = SELECT;
        end
      end
      SELECT: state_d = WAIT;
      WAIT: begin
        if (bus.alu_result_valid) begin
          state_d = WRITE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: synchronous reset clears every register, including the
      // captured fields and write data, so nothing stale survives a reset.
      state_q    <= IDLE;
      fields_q   <= '0;
      wait_cnt_q <= '0;
      wdata_q    <= '0;
`ifdef ALU_RR_ILLEGAL_TRAP_EN
      illegal_q  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so all registers update from the
      // values present before this edge.
      state_q <= state_d;
      if (accept) fields_q <= dec_fields;
      // Count only while staying in WAIT; entering WAIT always starts at 0.
      if ((state_q == WAIT) && (state_d == WAIT)) wait_cnt_q <= wait_cnt_q + 8'd1;
      else                                        wait_cnt_q <= '0;
      if ((state_q == WAIT) && bus.alu_result_valid) wdata_q <= bus.alu_result;
`ifdef ALU_RR_ILLEGAL_TRAP_EN
      illegal_q <= accept && dec_illegal;
`endif
    end
  end

  assign bus.instr_ready       = (state_q == IDLE);
  assign bus.alu_select_enable = (state_q == SELECT);
  assign bus.done              = (state_q == WRITE);
  // x0 is hardwired to zero, so a write to it is suppressed.
  assign bus.rd_we             = (state_q == WRITE) && (fields_q.rd != 5'd0);
  assign bus.timeout           = timeout_hit;
  assign bus.rs1_addr          = fields_q.rs1;
  assign bus.rs2_addr          = fields_q.rs2;
  assign bus.rd_addr           = fields_q.rd;
  assign bus.funct3            = fields_q.funct3;
  assign bus.funct7            = fields_q.funct7;
  assign bus.rd_wdata          = wdata_q;

endmodule
